vend_sequencer: RTL and testbench

VEND_SEQUENCER -- requirements
Module: vend_sequencer

---
 rtl/vend_sequencer.sv | 148 ++++++++++++++
 tb/tb_vend_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/vend_sequencer.sv
// Coin-operated vending sequencer: accepts Rs5/Rs10 coins, dispenses one of
// three products and refunds the remaining credit one Rs5 coin per cycle.
module vend_sequencer #(
    parameter int PRICE_1    = 5,
    parameter int PRICE_2    = 10,
    parameter int PRICE_3    = 15,
    parameter int CREDIT_MAX = 30,
    parameter int TIMEOUT    = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coin_valid,
    input  logic [1:0] coin_val,
    input  logic [1:0] product,
    input  logic       cancel,
    output logic [4:0] credit,
    output logic       product_1,
    output logic       product_2,
    output logic       product_3,
    output logic       change_coin,
    output logic       coin_reject,
    output logic       insufficient,
    output logic       busy
);

    // state    | meaning
    // IDLE     | no credit held, waiting for the first coin
    // COLLECT  | accumulating credit, waiting for selection/cancel/timeout
    // DISPENSE | one-cycle product pulse for the latched selection
    // CHANGE   | returning credit, one Rs5 coin per cycle
    typedef enum logic [1:0] {IDLE, COLLECT, DISPENSE, CHANGE} state_t;

    state_t     state_q, state_d;
    logic [4:0] credit_d;
    logic [7:0] timer_q, timer_d;
    logic [8:0] timer_inc;
    logic [1:0] sel_q, sel_d;
    logic       reject_d, insuf_d;
    logic       coin_ok, coin_fits;
    logic [5:0] coin_amt, credit_sum, price;

    always_comb begin
        coin_ok  = (coin_val == 2'b01) || (coin_val == 2'b10);
        coin_amt = (coin_val == 2'b01) ? 6'd5 : (coin_val == 2'b10) ? 6'd10 : 6'd0;
        // 6-bit sum so credit + 10 cannot wrap before the limit compare
        credit_sum = {1'b0, credit} + coin_amt;
        coin_fits  = coin_ok && (credit_sum <= 6'(CREDIT_MAX));
        case (product)
            2'b01:   price = 6'(PRICE_1);
            2'b10:   price = 6'(PRICE_2);
            2'b11:   price = 6'(PRICE_3);
            default: price = 6'd0;
        endcase
        timer_inc = {1'b0, timer_q} + 9'd1;
    end

    always_comb begin
        state_d  = state_q;
        credit_d = credit;
        timer_d  = timer_q;
        sel_d    = sel_q;
        reject_d = 1'b0;
        insuf_d  = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d = 8'd0;
                if (coin_valid) begin
                    if (coin_fits) begin
                        credit_d = credit_sum[4:0];
                        state_d  = COLLECT;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (cancel) begin
                    reject_d = coin_valid;
                    timer_d  = 8'd0;
                    state_d  = CHANGE;
                end else if (product != 2'b00) begin
                    reject_d = coin_valid;
                    timer_d  = 8'd0;
                    if ({1'b0, credit} >= price) begin
                        credit_d = credit - price[4:0];
                        sel_d    = product;
                        state_d  = DISPENSE;
                    end else begin
                        insuf_d = 1'b1;
                    end
                end else if (coin_valid) begin
                    timer_d = 8'd0;
                    if (coin_fits) credit_d = credit_sum[4:0];
                    else           reject_d = 1'b1;
                end else if (timer_inc == 9'(TIMEOUT)) begin
                    timer_d = 8'd0;
                    state_d = CHANGE;
                end else begin
                    timer_d = timer_inc[7:0];
                end
            end
            DISPENSE: begin
                reject_d = coin_valid;
                state_d  = (credit != 5'd0) ? CHANGE : IDLE;
            end
            CHANGE: begin
                reject_d = coin_valid;
                if (credit > 5'd5) begin
                    credit_d = credit - 5'd5;
                end else begin
                    credit_d = 5'd0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pulse outputs describe the state being entered, so they line up with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            credit       <= 5'd0;
            timer_q      <= 8'd0;
            sel_q        <= 2'b00;
            product_1    <= 1'b0;
            product_2    <= 1'b0;
            product_3    <= 1'b0;
            change_coin  <= 1'b0;
            coin_reject  <= 1'b0;
            insufficient <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            credit       <= credit_d;
            timer_q      <= timer_d;
            sel_q        <= sel_d;
            product_1    <= (state_d == DISPENSE) && (sel_d == 2'b01);
            product_2    <= (state_d == DISPENSE) && (sel_d == 2'b10);
            product_3    <= (state_d == DISPENSE) && (sel_d == 2'b11);
            change_coin  <= (state_d == CHANGE);
            coin_reject  <= reject_d;
            insufficient <= insuf_d;
            busy         <= (state_d == DISPENSE) || (state_d == CHANGE);
        end
    end

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed vector bench for vend_sequencer (TIMEOUT shortened to 4).
module tb_vend_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       coin_valid;
    logic [1:0] coin_val;
    logic [1:0] product;
    logic       cancel;
    logic [4:0] credit;
    logic       product_1, product_2, product_3;
    logic       change_coin, coin_reject, insufficient, busy;

    int checks = 0;
    int errors = 0;

    vend_sequencer #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_val(coin_val),
        .product(product), .cancel(cancel), .credit(credit),
        .product_1(product_1), .product_2(product_2), .product_3(product_3),
        .change_coin(change_coin), .coin_reject(coin_reject),
        .insufficient(insufficient), .busy(busy)
    );

    always #5 clk = ~clk;

    // expected packing: {credit[4:0], p1, p2, p3, change, reject, insuf, busy}
    typedef struct {
        logic       cv;
        logic [1:0] cval;
        logic [1:0] prod;
        logic       can;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic cv, input logic [1:0] cval, input logic [1:0] prod,
                                input logic can, input logic [4:0] cr, input logic [2:0] p,
                                input logic ch, input logic rj, input logic ins, input logic bz);
        vec_t v;
        v.cv = cv; v.cval = cval; v.prod = prod; v.can = can;
        v.exp = {cr, p, ch, rj, ins, bz};
        return v;
    endfunction

    function automatic logic [11:0] outs();
        return {credit, product_1, product_2, product_3, change_coin, coin_reject, insufficient, busy};
    endfunction

    task automatic drive(input logic cv, input logic [1:0] cval, input logic [1:0] prod, input logic can);
        coin_valid = cv; coin_val = cval; product = prod; cancel = can;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [11:0] exp);
        logic [11:0] got;
        got = outs();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got credit=%0d p123=%b chg=%b rej=%b ins=%b busy=%b, expected credit=%0d p123=%b chg=%b rej=%b ins=%b busy=%b",
                     name, got[11:7], got[6:4], got[3], got[2], got[1], got[0],
                     exp[11:7], exp[6:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 2'b00, 2'b00, 1'b0);
        tick();
        check("reset_idle", 12'd0);
        drive(1'b1, 2'b10, 2'b11, 1'b1);
        tick();
        check("reset_with_inputs", 12'd0);
        reset = 1'b0;

        // REQ-034 style: Rs10, Rs10, product 3, one change coin
        vecs.push_back(mk(1, 2'b10, 2'b00, 0, 10, 3'b000, 0, 0, 0, 0));
        vecs.push_back(mk(1, 2'b10, 2'b00, 0, 20, 3'b000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 2'b00, 2'b11, 0,  5, 3'b001, 0, 0, 0, 1));
        vecs.push_back(mk(0, 2'b00, 2'b00, 0,  5, 3'b000, 1, 0, 0, 1));
        vecs.push_back(mk(0, 2'b00, 2'b00, 0,  0, 3'b000, 0, 0, 0, 0));
        // insufficient then exact purchase, no change
        vecs.push_back(mk(1, 2'b01, 2'b00, 0,  5, 3'b000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 2'b00, 2'b10, 0,  5, 3'b000, 0, 0, 1, 0));
        vecs.push_back(mk(1, 2'b01, 2'b00, 0, 10, 3'b000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 2'b00, 2'b10, 0,  0, 3'b010, 0, 0, 0, 1));
        vecs.push_back(mk(0, 2'b00, 2'b00, 0,  0, 3'b000, 0, 0, 0, 0));
        // credit limit, then cancel with six refund pulses
        vecs.push_back(mk(1, 2'b10, 2'b00, 0, 10, 3'b000, 0, 0, 0, 0));
        vecs.push_back(mk(1, 2'b10, 2'b00, 0, 20, 3'b000, 0, 0, 0, 0));
        vecs.push_back(mk(1, 2'b01, 2'b00, 0, 25, 3'b000, 0, 0, 0, 0));
        vecs.push_back(mk(1, 2'b10, 2'b00, 0, 25, 3'b000, 0, 1, 0, 0));
        vecs.push_back(mk(1, 2'b01, 2'b00, 0, 30, 3'b000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 2'b00, 2'b00, 1, 30, 3'b000, 1, 0, 0, 1));
        vecs.push_back(mk(0, 2'b00, 2'b00, 0, 25, 3'b000, 1, 0, 0, 1));
        vecs.push_back(mk(0, 2'b00, 2'b00, 0, 20, 3'b000, 1, 0, 0, 1));
        vecs.push_back(mk(1, 2'b01, 2'b00, 0, 15, 3'b000, 1, 1, 0, 1));
        vecs.push_back(mk(0, 2'b00, 2'b01, 1, 10, 3'b000, 1, 0, 0, 1));
        vecs.push_back(mk(0, 2'b00, 2'b00, 0,  5, 3'b000, 1, 0, 0, 1));
        vecs.push_back(mk(0, 2'b00, 2'b00, 0,  0, 3'b000, 0, 0, 0, 0));
        // selection with same-cycle coin: coin rejected, product 1, two refunds
        vecs.push_back(mk(1, 2'b10, 2'b00, 0, 10, 3'b000, 0, 0, 0, 0));
        vecs.push_back(mk(1, 2'b01, 2'b00, 0, 15, 3'b000, 0, 0, 0, 0));
        vecs.push_back(mk(1, 2'b01, 2'b01, 0, 10, 3'b100, 0, 1, 0, 1));
        vecs.push_back(mk(0, 2'b00, 2'b00, 0, 10, 3'b000, 1, 0, 0, 1));
        vecs.push_back(mk(0, 2'b00, 2'b00, 0,  5, 3'b000, 1, 0, 0, 1));
        vecs.push_back(mk(0, 2'b00, 2'b00, 0,  0, 3'b000, 0, 0, 0, 0));
        // invalid coin codes, cancel with same-cycle coin
        vecs.push_back(mk(1, 2'b01, 2'b00, 0,  5, 3'b000, 0, 0, 0, 0));
        vecs.push_back(mk(1, 2'b11, 2'b00, 0,  5, 3'b000, 0, 1, 0, 0));
        vecs.push_back(mk(1, 2'b10, 2'b00, 1,  5, 3'b000, 1, 1, 0, 1));
        vecs.push_back(mk(0, 2'b00, 2'b00, 0,  0, 3'b000, 0, 0, 0, 0));
        // IDLE ignores selection/cancel, rejects invalid coin
        vecs.push_back(mk(0, 2'b00, 2'b11, 1,  0, 3'b000, 0, 0, 0, 0));
        vecs.push_back(mk(1, 2'b00, 2'b00, 0,  0, 3'b000, 0, 1, 0, 0));
        // cancel takes priority over selection
        vecs.push_back(mk(1, 2'b10, 2'b00, 0, 10, 3'b000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 2'b00, 2'b01, 1, 10, 3'b000, 1, 0, 0, 1));
        vecs.push_back(mk(0, 2'b00, 2'b00, 0,  5, 3'b000, 1, 0, 0, 1));
        vecs.push_back(mk(0, 2'b00, 2'b00, 0,  0, 3'b000, 0, 0, 0, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].cv, vecs[i].cval, vecs[i].prod, vecs[i].can);
            tick();
            check($sformatf("vec[%0d]", i), vecs[i].exp);
        end

        // timeout: credit 10, four idle COLLECT cycles then refund
        drive(1, 2'b10, 2'b00, 0);
        tick();
        check("to_coin", {5'd10, 7'b0000000});
        drive(0, 2'b00, 2'b00, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("to_wait%0d", i), {5'd10, 7'b0000000});
        end
        tick();
        check("to_change1", {5'd10, 3'b000, 4'b1001});
        tick();
        check("to_change2", {5'd5, 3'b000, 4'b1001});
        tick();
        check("to_idle", 12'd0);

        // a coin restarts the timeout count
        drive(1, 2'b01, 2'b00, 0);
        tick();
        drive(0, 2'b00, 2'b00, 0);
        tick(); tick(); tick();
        check("tr_before", {5'd5, 7'b0000000});
        drive(1, 2'b01, 2'b00, 0);
        tick();
        drive(0, 2'b00, 2'b00, 0);
        tick(); tick(); tick();
        check("tr_restarted", {5'd10, 7'b0000000});
        tick();
        check("tr_expired", {5'd10, 3'b000, 4'b1001});
        tick(); tick();
        check("tr_idle", 12'd0);

        // reset during the second of four refund pulses
        drive(1, 2'b10, 2'b00, 0);
        tick();
        tick();
        drive(0, 2'b00, 2'b00, 1);
        tick();
        check("rr_pulse1", {5'd20, 3'b000, 4'b1001});
        drive(0, 2'b00, 2'b00, 0);
        tick();
        check("rr_pulse2", {5'd15, 3'b000, 4'b1001});
        reset = 1'b1;
        tick();
        check("rr_reset", 12'd0);
        reset = 1'b0;
        tick();
        check("rr_after", 12'd0);

        // reset during dispense
        drive(1, 2'b10, 2'b00, 0);
        tick();
        drive(0, 2'b00, 2'b01, 0);
        tick();
        check("rd_dispense", {5'd5, 3'b100, 4'b0001});
        drive(0, 2'b00, 2'b00, 0);
        reset = 1'b1;
        tick();
        check("rd_reset", 12'd0);
        reset = 1'b0;
        tick();
        check("rd_after", 12'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
